wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 94 +++++++++
 tb/tb_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Four-requester round-robin arbiter in front of a single register-file
// write port. The grant is combinational. The winning address and data are
// registered and presented as a one-cycle write on the following cycle.
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                    iClk,
    input  logic                    iReset_n,
    input  logic [3:0]              iReq,
    input  logic [4*ADDR_W-1:0]     iAddr,
    input  logic [4*DATA_WIDTH-1:0] iData,
    input  logic                    iStall,
    output logic [3:0]              oGnt,
    output logic [1:0]              oSel,
    output logic                    oWrEn,
    output logic [ADDR_W-1:0]       oWrAddr,
    output logic [DATA_WIDTH-1:0]   oWrData,
    output logic [15:0]             oStallCnt
);

    // Handshake: requester k raises iReq[k] and holds iReq/iAddr/iData
    // stable until it sees oGnt[k] high in a cycle. That cycle is the
    // transfer, and the requester may drop or change its request afterwards.
    // A request withdrawn before its grant is never granted. iStall blocks
    // every grant in the cycle it is high. It never cancels a write that is
    // already registered.

    logic [1:0]            rPtr;
    logic [ADDR_W-1:0]     addrArr [4];
    logic [DATA_WIDTH-1:0] dataArr [4];
    logic                  gntValid;
    logic [1:0]            gntIdx;
    logic [1:0]            cand;
    logic                  found;

    // Unpack the packed requester buses into indexable arrays
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            addrArr[k] = iAddr[k*ADDR_W +: ADDR_W];
            dataArr[k] = iData[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting at rPtr. Reset and stall suppress any grant.
    always_comb begin
        found  = 1'b0;
        gntIdx = 2'd0;
        cand   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = rPtr + 2'(i);
            if (!found && iReq[cand]) begin
                found  = 1'b1;
                gntIdx = cand;
            end
        end
        gntValid = found && !iStall && iReset_n;
    end

    // One-hot grant vector for the requesters
    always_comb begin
        oGnt = 4'b0000;
        if (gntValid) begin
            oGnt[gntIdx] = 1'b1;
        end
    end

    // Pointer, registered write port and stall counter
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rPtr      <= 2'd0;
            oSel      <= 2'd0;
            oWrEn     <= 1'b0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oStallCnt <= 16'd0;
        end else begin
            if (gntValid) begin
                rPtr    <= gntIdx + 2'd1;
                oSel    <= gntIdx;
                oWrAddr <= addrArr[gntIdx];
                oWrData <= dataArr[gntIdx];
                // Register $zero is hardwired, so this request is consumed without a write
                oWrEn   <= (addrArr[gntIdx] != '0);
            end else begin
                oWrEn <= 1'b0;
            end
            if (iStall && (iReq != 4'b0000) && (oStallCnt != 16'hFFFF)) begin
                oStallCnt <= oStallCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter. A reference model of the round-robin rules
// predicts each grant, the registered write, and the stall count.
module tb_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic            iClk = 1'b0;
    logic            iReset_n;
    logic [3:0]      iReq;
    logic [4*AW-1:0] iAddr;
    logic [4*DW-1:0] iData;
    logic            iStall;
    logic [3:0]      oGnt;
    logic [1:0]      oSel;
    logic            oWrEn;
    logic [AW-1:0]   oWrAddr;
    logic [DW-1:0]   oWrData;
    logic [15:0]     oStallCnt;

    int nChecks = 0;
    int nFails  = 0;

    // Model state
    int            mPtr;
    logic [1:0]    mSel;
    logic          mWrEn;
    logic [AW-1:0] mWrAddr;
    logic [DW-1:0] mWrData;
    int            mStallCnt;

    // Expected writes: {sel, addr, data}
    logic [AW+DW+1:0] exp_q[$];

    wb_arbiter #(.DATA_WIDTH(DW), .ADDR_W(AW)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iReq(iReq), .iAddr(iAddr),
        .iData(iData), .iStall(iStall), .oGnt(oGnt), .oSel(oSel),
        .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
        .oStallCnt(oStallCnt)
    );

    // Clock
    always #5 iClk = ~iClk;

    // Reference model: first requesting index in order ptr, ptr+1, ... mod 4
    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] expGnt();
        int k;
        if (!iReset_n || iStall) return 4'b0000;
        k = pick(iReq, mPtr);
        if (k < 0) return 4'b0000;
        return 4'(1 << k);
    endfunction

    task automatic modelReset();
        mPtr = 0; mSel = 2'd0; mWrEn = 1'b0; mWrAddr = '0; mWrData = '0;
        mStallCnt = 0;
        exp_q.delete();
    endtask

    // Driver: set one requester's slices
    task automatic setReq(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iAddr[k*AW +: AW] = a;
        iData[k*DW +: DW] = d;
    endtask

    // Wait until mid-cycle so the combinational outputs have settled
    task automatic settle();
        @(negedge iClk);
    endtask

    // Advance one rising edge. Update the model with what that edge commits.
    task automatic clockEdge();
        int k;
        logic stallCount;
        k = (iReset_n && !iStall) ? pick(iReq, mPtr) : -1;
        stallCount = iReset_n && iStall && (iReq != 4'b0000);
        @(posedge iClk);
        if (!iReset_n) begin
            modelReset();
        end else begin
            if (k >= 0) begin
                mPtr    = (k + 1) % 4;
                mSel    = 2'(k);
                mWrAddr = iAddr[k*AW +: AW];
                mWrData = iData[k*DW +: DW];
                mWrEn   = (mWrAddr != '0);
                if (mWrEn) exp_q.push_back({mSel, mWrAddr, mWrData});
            end else begin
                mWrEn = 1'b0;
            end
            if (stallCount && mStallCnt < 65535) mStallCnt++;
        end
        #1;
    endtask

    task automatic doReset();
        iReset_n = 1'b0; iReq = 4'b0000; iStall = 1'b0; iAddr = '0; iData = '0;
        modelReset();
        clockEdge();
        clockEdge();
        iReset_n = 1'b1;
    endtask

    task automatic test_reset();
        iReset_n = 1'b0; iStall = 1'b0; iReq = 4'b1111;
        modelReset();
        #3;
        nChecks++;
        if (oGnt !== 4'b0000) begin nFails++; $display("FAIL reset_gnt: got %b expected 0000", oGnt); end
        nChecks++;
        if (oWrEn !== 1'b0 || oSel !== 2'd0) begin nFails++; $display("FAIL reset_wr: got wrEn=%b sel=%0d expected 0/0", oWrEn, oSel); end
        nChecks++;
        if (oWrAddr !== '0 || oWrData !== '0) begin nFails++; $display("FAIL reset_data: got addr=%0h data=%0h expected 0/0", oWrAddr, oWrData); end
        nChecks++;
        if (oStallCnt !== 16'd0) begin nFails++; $display("FAIL reset_stallcnt: got %0d expected 0", oStallCnt); end
        clockEdge();
        iReset_n = 1'b1; iReq = 4'b0000;
        clockEdge();
    endtask

    task automatic test_rotation();
        int seq [5] = '{0, 1, 2, 3, 0};
        doReset();
        for (int k = 0; k < 4; k++) setReq(k, AW'(k + 1), $urandom);
        iReq = 4'b1111;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) iReq = 4'b0000;
            settle();
            if (c < 5) begin
                nChecks++;
                if (oGnt !== 4'(1 << seq[c]) || oGnt !== expGnt()) begin
                    nFails++; $display("FAIL rotation_gnt[%0d]: got %b expected %b", c, oGnt, 4'(1 << seq[c]));
                end
            end
            if (c > 0) begin
                nChecks++;
                if (oWrEn !== 1'b1 || oSel !== 2'(seq[c-1]) || oWrAddr !== mWrAddr || oWrData !== mWrData) begin
                    nFails++; $display("FAIL rotation_wr[%0d]: got en=%b sel=%0d addr=%0h data=%0h expected 1/%0d/%0h/%0h",
                                       c, oWrEn, oSel, oWrAddr, oWrData, seq[c-1], mWrAddr, mWrData);
                end
            end
            clockEdge();
        end
    endtask

    task automatic test_single_write();
        iStall = 1'b0;
        setReq(2, 5'd9, 32'hDEADBEEF);
        iReq = 4'b0100;
        settle();
        nChecks++;
        if (oGnt !== 4'b0100) begin nFails++; $display("FAIL single_gnt: got %b expected 0100", oGnt); end
        clockEdge();
        iReq = 4'b0000;
        settle();
        nChecks++;
        if (oWrEn !== 1'b1 || oSel !== 2'd2 || oWrAddr !== 5'd9 || oWrData !== 32'hDEADBEEF) begin
            nFails++; $display("FAIL single_wr: got en=%b sel=%0d addr=%0d data=%0h expected 1/2/9/deadbeef", oWrEn, oSel, oWrAddr, oWrData);
        end
        clockEdge();
        settle();
        nChecks++;
        if (oWrEn !== 1'b0 || oWrAddr !== 5'd9 || oWrData !== 32'hDEADBEEF) begin
            nFails++; $display("FAIL single_hold: got en=%b addr=%0d data=%0h expected 0/9/deadbeef", oWrEn, oWrAddr, oWrData);
        end
        clockEdge();
    endtask

    task automatic test_zero_addr();
        for (int k = 0; k < 4; k++) setReq(k, AW'(k + 4), $urandom);
        setReq(1, 5'd0, $urandom);
        iReq = 4'b0010;
        settle();
        nChecks++;
        if (oGnt !== 4'b0010) begin nFails++; $display("FAIL zero_gnt: got %b expected 0010", oGnt); end
        clockEdge();
        iReq = 4'b1111;
        settle();
        nChecks++;
        if (oWrEn !== 1'b0 || oSel !== 2'd1) begin nFails++; $display("FAIL zero_wr: got en=%b sel=%0d expected 0/1", oWrEn, oSel); end
        nChecks++;
        if (oGnt !== 4'b0100) begin nFails++; $display("FAIL zero_ptr: got %b expected 0100", oGnt); end
        clockEdge();
        iReq = 4'b0000;
        clockEdge();
    endtask

    task automatic test_stall();
        doReset();
        for (int k = 0; k < 4; k++) setReq(k, AW'(k + 1), $urandom);
        iReq = 4'b1001;
        iStall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            nChecks++;
            if (oGnt !== 4'b0000) begin nFails++; $display("FAIL stall_gnt[%0d]: got %b expected 0000", c, oGnt); end
            clockEdge();
        end
        iStall = 1'b0;
        settle();
        nChecks++;
        if (oStallCnt !== 16'd3) begin nFails++; $display("FAIL stall_cnt: got %0d expected 3", oStallCnt); end
        nChecks++;
        if (oGnt !== 4'b0001) begin nFails++; $display("FAIL stall_release: got %b expected 0001", oGnt); end
        clockEdge();
        iReq = 4'b0000;
        clockEdge();
    endtask

    task automatic test_random();
        logic [AW+DW+1:0] e;
        doReset();
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 4; k++)
                setReq(k, ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom), $urandom);
            iReq   = 4'($urandom);
            iStall = ($urandom_range(0, 3) == 0);
            settle();
            nChecks++;
            if (oGnt !== expGnt()) begin nFails++; $display("FAIL random_gnt[%0d]: got %b expected %b", c, oGnt, expGnt()); end
            nChecks++;
            if (oWrEn !== mWrEn) begin nFails++; $display("FAIL random_wren[%0d]: got %b expected %b", c, oWrEn, mWrEn); end
            if (oWrEn === 1'b1) begin
                nChecks++;
                if (exp_q.size() == 0) begin
                    nFails++; $display("FAIL random_sb[%0d]: got unexpected write sel=%0d expected none", c, oSel);
                end else begin
                    e = exp_q.pop_front();
                    if ({oSel, oWrAddr, oWrData} !== e) begin
                        nFails++; $display("FAIL random_sb[%0d]: got %0h expected %0h", c, {oSel, oWrAddr, oWrData}, e);
                    end
                end
            end
            nChecks++;
            if (oStallCnt !== 16'(mStallCnt)) begin nFails++; $display("FAIL random_stallcnt[%0d]: got %0d expected %0d", c, oStallCnt, mStallCnt); end
            clockEdge();
        end
        iReq = 4'b0000; iStall = 1'b0;
        clockEdge();
    endtask

    task automatic test_reset_mid_write();
        doReset();
        setReq(3, 5'd17, 32'h12345678);
        iReq = 4'b1000;
        clockEdge();
        iReq = 4'b1111;
        #1;
        nChecks++;
        if (oWrEn !== 1'b1 || oSel !== 2'd3) begin nFails++; $display("FAIL midreset_pre: got en=%b sel=%0d expected 1/3", oWrEn, oSel); end
        iReset_n = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (oWrEn !== 1'b0 || oGnt !== 4'b0000) begin nFails++; $display("FAIL midreset_drop: got en=%b gnt=%b expected 0/0000", oWrEn, oGnt); end
        clockEdge();
        iReset_n = 1'b1;
        settle();
        nChecks++;
        if (oGnt !== 4'b0001) begin nFails++; $display("FAIL midreset_resume: got %b expected 0001", oGnt); end
        clockEdge();
        iReq = 4'b0000;
        clockEdge();
    endtask

    task automatic test_stall_saturation();
        doReset();
        iReq = 4'b0001;
        iStall = 1'b1;
        for (int c = 0; c < 65534; c++) clockEdge();
        settle();
        nChecks++;
        if (oStallCnt !== 16'hFFFE) begin nFails++; $display("FAIL sat_preload: got %0h expected fffe", oStallCnt); end
        for (int c = 0; c < 3; c++) clockEdge();
        settle();
        nChecks++;
        if (oStallCnt !== 16'hFFFF || oStallCnt !== 16'(mStallCnt)) begin
            nFails++; $display("FAIL sat_hold: got %0h expected ffff", oStallCnt);
        end
        iStall = 1'b0; iReq = 4'b0000;
        clockEdge();
    endtask

    initial begin
        iReset_n = 1'b0; iReq = 4'b0000; iStall = 1'b0; iAddr = '0; iData = '0;
        modelReset();
        test_reset();
        test_rotation();
        test_single_write();
        test_zero_addr();
        test_stall();
        test_random();
        test_reset_mid_write();
        test_stall_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
